subkey_store: RTL
=================

Name: subkey_store

Overview:
- Receiving end of the key_schedule subkey stream: captures the 33 Serpent round subkeys presented as (o_subkey, o_address, o_subkey_valid) into a local register file.
- Serves them to the bitslice round datapath through a 1-cycle-latency read port.
- Tracks load completeness and flags protocol errors (out-of-range address, duplicate write, write outside a load).
- Sits between key_schedule and the encrypt/decrypt round controller.

Parameters:
- NUM_SUBKEYS, 33, number of subkeys per key load (Serpent: 32 rounds + 1).
- KEY_W, 128, subkey width in bits.
- ADDR_W, 6, subkey address width; must satisfy 2**ADDR_W >= NUM_SUBKEYS.

Ports:
- i_clk  input  1  clock; all logic is on the rising edge.
- i_rstn  input  1  reset; asynchronous assert, active-low.
- i_begin  input  1  new key load starting (same pulse that drives key_schedule i_begin); invalidates the store.
- i_subkey  input  KEY_W  subkey from key_schedule.
- i_address  input  ADDR_W  subkey index from key_schedule.
- i_subkey_valid  input  1  write strobe; one subkey per asserted cycle.
- i_rd_req  input  1  read request from round controller.
- i_rd_addr  input  ADDR_W  subkey index to read.
- o_rd_data  output  KEY_W  read data, valid when o_rd_valid=1.
- o_rd_valid  output  1  1-cycle pulse, one cycle after an accepted i_rd_req.
- o_keys_ready  output  1  all NUM_SUBKEYS entries written for the current load.
- o_error  output  1  sticky protocol error; cleared by i_begin or reset.

Behaviour:
- Reset (async, i_rstn=0): state=EMPTY; written-bitmap=0; count=0; o_rd_data=0; o_rd_valid=0; o_keys_ready=0; o_error=0. The register file is not reset.
- FSM states: EMPTY, LOADING, READY.
  - EMPTY -> LOADING on i_begin.
  - LOADING -> READY when the count reaches NUM_SUBKEYS. o_keys_ready rises the cycle after the final write.
  - READY -> LOADING on i_begin.
  - Any state, i_begin: clear bitmap, count, o_error and o_keys_ready next cycle.
- Write, LOADING only, i_subkey_valid=1:
  - If i_address < NUM_SUBKEYS: mem[i_address] <= i_subkey.
  - First write to an address: set its bitmap bit and increment count.
  - Duplicate address: overwrite, count unchanged, set o_error.
- i_address >= NUM_SUBKEYS: write ignored, o_error set.
- i_subkey_valid in EMPTY or READY: ignored, o_error set.
- i_begin together with i_subkey_valid in the same cycle: i_begin wins; the write is discarded and does not set o_error.
- i_begin mid-LOADING: restart cleanly. Old mem contents remain but are invisible until rewritten.
- Read, READY only:
  - i_rd_req=1 with i_rd_addr < NUM_SUBKEYS: next cycle o_rd_data=mem[i_rd_addr], o_rd_valid=1.
  - Back-to-back reads sustain 1 per cycle.
  - Out-of-range i_rd_addr: o_rd_valid=1, o_rd_data=0, o_error set.
- i_rd_req when not READY: dropped (o_rd_valid stays 0, o_rd_data holds), no error.
- READY and i_begin in the same cycle as i_rd_req: read dropped.
- o_rd_data holds its last value when o_rd_valid=0.

Optional Feature:
- Macro SUBKEY_ZEROIZE_EN.
- When defined:
  - Adds input i_zeroize (1 bit) and state ZEROIZE.
  - i_zeroize in any state enters ZEROIZE, which writes 0 to mem[0..NUM_SUBKEYS-1] over exactly NUM_SUBKEYS cycles, then goes to EMPTY.
  - In ZEROIZE: bitmap/count cleared, o_keys_ready=0, o_rd_data forced to 0, reads dropped, writes ignored without error, i_begin ignored.
  - i_zeroize wins over i_begin in the same cycle.
- When undefined: no port, no state, behaviour as above.

Decomposition:
- Package serpent_ks_pkg: NUM_SUBKEYS, KEY_W, ADDR_W localparams; state enum encoding (EMPTY=0, LOADING=1, READY=2, ZEROIZE=3).
- One sub-module subkey_regfile: NUM_SUBKEYS x KEY_W, one write port, one registered read port.
- FSM, bitmap, count and error logic stay in the top.

Test Plan:
- In-order load: i_begin, then addr 0..32 with subkey = {4{32'hA5A5_0000 | addr}} -> o_keys_ready=1 one cycle after addr 32. Read addr 7 -> next cycle o_rd_data = 128'hA5A5_0007 replicated x4, o_rd_valid=1.
- Out-of-order load: addrs written in order 32..0 -> o_keys_ready=1 after the 33rd write, o_error=0; back-to-back reads of 0..32 -> 33 consecutive o_rd_valid pulses with correct data.
- Protocol errors:
  - Write addr 5 twice -> o_error=1, o_keys_ready stays 0 until 33 distinct addresses are written.
  - Write addr 40 -> o_error=1, mem unchanged.
  - Next i_begin -> o_error=0.
- Restart mid-load: 10 writes, then i_begin -> o_keys_ready=0 until 33 new distinct writes. Read before READY -> o_rd_valid stays 0.
- i_begin and i_subkey_valid same cycle -> write discarded, count=0, o_error=0. Async reset asserted mid-read -> o_rd_valid=0 and o_keys_ready=0 immediately, without waiting for a clock edge.
- With SUBKEY_ZEROIZE_EN: after a full load, pulse i_zeroize -> 33 cycles in ZEROIZE, then EMPTY. Reload only addr 0, force READY via a full 33-write load, read addr 0 -> written value returned.

Source files
------------

// File: rtl/serpent_ks_pkg.sv
// Shared constants, FSM encoding and address helper for the Serpent subkey store.
// Optional zeroize support is selected elsewhere with SUBKEY_ZEROIZE_EN.
package serpent_ks_pkg;

  localparam int NUM_SUBKEYS = 33;
  localparam int KEY_W       = 128;
  localparam int ADDR_W      = 6;
  localparam int CNT_W       = $clog2(NUM_SUBKEYS + 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2,
    ST_ZEROIZE = 2'd3
  } state_e;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(NUM_SUBKEYS);
  endfunction

endpackage

// File: rtl/subkey_store_if.sv
// Subkey write stream plus round-controller read port of the subkey store.
// i_zeroize exists only when SUBKEY_ZEROIZE_EN is defined.
interface subkey_store_if;
  import serpent_ks_pkg::*;

  logic              i_begin;
  logic [KEY_W-1:0]  i_subkey;
  logic [ADDR_W-1:0] i_address;
  logic              i_subkey_valid;
  logic              i_rd_req;
  logic [ADDR_W-1:0] i_rd_addr;
  logic [KEY_W-1:0]  o_rd_data;
  logic              o_rd_valid;
  logic              o_keys_ready;
  logic              o_error;
`ifdef SUBKEY_ZEROIZE_EN
  logic              i_zeroize;
`endif

  modport master (
`ifdef SUBKEY_ZEROIZE_EN
    output i_zeroize,
`endif
    output i_begin, i_subkey, i_address, i_subkey_valid, i_rd_req, i_rd_addr,
    input  o_rd_data, o_rd_valid, o_keys_ready, o_error
  );

  modport slave (
`ifdef SUBKEY_ZEROIZE_EN
    input  i_zeroize,
`endif
    input  i_begin, i_subkey, i_address, i_subkey_valid, i_rd_req, i_rd_addr,
    output o_rd_data, o_rd_valid, o_keys_ready, o_error
  );

endinterface

// File: rtl/subkey_store_regfile.sv
// Subkey register file: one write port, one registered read port, no reset so it maps to block RAM.
module subkey_regfile
  import serpent_ks_pkg::*;
#(
  parameter int DEPTH = NUM_SUBKEYS,
  parameter int WIDTH = KEY_W,
  parameter int AW    = ADDR_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/subkey_store.sv
// Captures the 33 Serpent round subkeys, tracks load completeness and protocol errors,
// and serves subkeys with 1-cycle latency. SUBKEY_ZEROIZE_EN adds the ZEROIZE wipe state.
module subkey_store
  import serpent_ks_pkg::*;
(
  input logic           i_clk,
  input logic           i_rstn,
  subkey_store_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SUBKEYS - 1);

  state_e                 state_reg, state_next;
  logic [NUM_SUBKEYS-1:0] bitmap_reg, bitmap_next;
  logic [CNT_W-1:0]       count_reg, count_next;
  logic                   error_reg, rd_valid_reg, rd_zero_reg;
  logic                   wr_in_range, rd_in_range, zeroize_req;
  logic                   clear, zero_mode, wipe, new_write, proto_err, rd_accept, last_write;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_waddr;
  logic [KEY_W-1:0]       mem_wdata, rd_q;

  assign wr_in_range = addr_in_range(bus.i_address);
  assign rd_in_range = addr_in_range(bus.i_rd_addr);

`ifdef SUBKEY_ZEROIZE_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SUBKEYS - 1);
  logic [ADDR_W-1:0] zcnt_reg;

  assign zeroize_req = bus.i_zeroize;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      zcnt_reg <= '0;
    end else if (zeroize_req) begin
      zcnt_reg <= '0;
    end else if (state_reg == ST_ZEROIZE) begin
      zcnt_reg <= zcnt_reg + ADDR_W'(1);
    end
  end
`else
  assign zeroize_req = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg <= ST_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
`ifdef SUBKEY_ZEROIZE_EN
    if (zeroize_req) begin
      state_next = ST_ZEROIZE;
    end else if (state_reg == ST_ZEROIZE) begin
      if (zcnt_reg == LAST_ADDR) begin
        state_next = ST_EMPTY;
      end
    end else
`endif
    if (bus.i_begin) begin
      state_next = ST_LOADING;
    end else if (last_write) begin
      state_next = ST_READY;
    end
  end

  // A begin or zeroize in the same cycle pre-empts any write or read decode.
  always_comb begin
    clear     = 1'b0;
    zero_mode = 1'b0;
    new_write = 1'b0;
    proto_err = 1'b0;
    rd_accept = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = bus.i_address;
    mem_wdata = bus.i_subkey;
    case (state_reg)
`ifdef SUBKEY_ZEROIZE_EN
      ST_ZEROIZE: begin
        zero_mode = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = zcnt_reg;
        mem_wdata = '0;
      end
`endif
      default: begin
        if (!zeroize_req) begin
          if (bus.i_begin) begin
            clear = 1'b1;
          end else begin
            if (bus.i_subkey_valid) begin
              if (state_reg != ST_LOADING || !wr_in_range) begin
                proto_err = 1'b1;
              end else begin
                mem_we = 1'b1;
                if (bitmap_reg[bus.i_address]) begin
                  proto_err = 1'b1;
                end else begin
                  new_write = 1'b1;
                end
              end
            end
            if (bus.i_rd_req && state_reg == ST_READY) begin
              rd_accept = 1'b1;
              if (!rd_in_range) begin
                proto_err = 1'b1;
              end
            end
          end
        end
      end
    endcase
  end

  assign wipe       = clear | zero_mode | zeroize_req;
  assign last_write = new_write && (count_reg == LAST_CNT);
  assign count_next = wipe ? '0 : (new_write ? count_reg + CNT_W'(1) : count_reg);

  for (genvar gi = 0; gi < NUM_SUBKEYS; gi++) begin : g_bitmap
    assign bitmap_next[gi] = !wipe &&
                             (bitmap_reg[gi] || (new_write && bus.i_address == ADDR_W'(gi)));
  end

  // rd_zero_reg selects a zero data word and holds that choice until the next accepted read.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      bitmap_reg   <= '0;
      count_reg    <= '0;
      error_reg    <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_zero_reg  <= 1'b1;
    end else begin
      bitmap_reg   <= bitmap_next;
      count_reg    <= count_next;
      error_reg    <= clear ? 1'b0 : (error_reg | proto_err);
      rd_valid_reg <= rd_accept;
      if (zero_mode) begin
        rd_zero_reg <= 1'b1;
      end else if (rd_accept) begin
        rd_zero_reg <= !rd_in_range;
      end
    end
  end

  subkey_regfile u_regfile (
    .clk   (i_clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (rd_accept && rd_in_range),
    .raddr (bus.i_rd_addr),
    .rdata (rd_q)
  );

  assign bus.o_keys_ready = (state_reg == ST_READY);
  assign bus.o_error      = error_reg;
  assign bus.o_rd_valid   = rd_valid_reg;
  assign bus.o_rd_data    = (rd_zero_reg || zero_mode) ? '0 : rd_q;

endmodule
